// File: rtl/seq_hit_pkg.sv
// Shared definitions for the detection-event counter: FSM encoding, BCD digit
// width and active-high seven-segment glyphs ordered {g,f,e,d,c,b,a}.
package seq_hit_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seq_hit_counter_bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; codes A-F blank the digit.
module bcd_to_7seg
  import seq_hit_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  logic [6:0] glyph_s;

  // Glyph lookup in active-high form, then polarity applied.
  always_comb begin
    glyph_s = SEG_BLANK;
    case (digit)
      4'd0:    glyph_s = SEG_0;
      4'd1:    glyph_s = SEG_1;
      4'd2:    glyph_s = SEG_2;
      4'd3:    glyph_s = SEG_3;
      4'd4:    glyph_s = SEG_4;
      4'd5:    glyph_s = SEG_5;
      4'd6:    glyph_s = SEG_6;
      4'd7:    glyph_s = SEG_7;
      4'd8:    glyph_s = SEG_8;
      4'd9:    glyph_s = SEG_9;
      default: glyph_s = SEG_BLANK;
    endcase
    if (SEG_ACTIVE_LOW) begin
      seg = ~glyph_s;
    end else begin
      seg = glyph_s;
    end
  end

endmodule

// File: rtl/seq_hit_counter.sv
// Counts 0->1 transitions of det as a two-digit BCD value with sticky wrap,
// tracks current/longest run length and drives two seven-segment digits.
module seq_hit_counter
  import seq_hit_pkg::*;
#(
  parameter int RUN_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic             clr,
  output logic             hit_pulse,
  output logic [7:0]       hit_bcd,
  output logic             wrapped,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] max_run,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1
);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             event_s;
  logic             active_det_s;
  logic [7:0]       bcd_base_s;
  logic             wrapped_base_s;
  logic [RUN_W-1:0] run_base_s;
  logic [RUN_W-1:0] max_base_s;
  logic [7:0]       bcd_nxt_s;
  logic             wrapped_nxt_s;
  logic [RUN_W-1:0] run_nxt_s;
  logic [RUN_W-1:0] max_nxt_s;

  // Next-state logic; a detection event is det seen high while IDLE.
  always_comb begin
    state_nxt_s  = state_r;
    event_s      = 1'b0;
    active_det_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (det) begin
          state_nxt_s = ST_ACTIVE;
          event_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (det) begin
          state_nxt_s  = ST_ACTIVE;
          active_det_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Statistics update; clr zeroes the base first so a same-edge event counts after it.
  always_comb begin
    bcd_base_s     = hit_bcd;
    wrapped_base_s = wrapped;
    run_base_s     = run_len;
    max_base_s     = max_run;
    if (clr) begin
      bcd_base_s     = 8'h00;
      wrapped_base_s = 1'b0;
      run_base_s     = {RUN_W{1'b0}};
      max_base_s     = {RUN_W{1'b0}};
    end else begin
      bcd_base_s     = hit_bcd;
    end

    bcd_nxt_s     = bcd_base_s;
    wrapped_nxt_s = wrapped_base_s;
    run_nxt_s     = run_base_s;
    max_nxt_s     = max_base_s;

    if (event_s) begin
      if (bcd_base_s[3:0] == 4'd9) begin
        bcd_nxt_s[3:0] = 4'd0;
        if (bcd_base_s[7:4] == 4'd9) begin
          bcd_nxt_s[7:4] = 4'd0;
          wrapped_nxt_s  = 1'b1;
        end else begin
          bcd_nxt_s[7:4] = bcd_base_s[7:4] + 4'd1;
        end
      end else begin
        bcd_nxt_s[3:0] = bcd_base_s[3:0] + 4'd1;
      end
      run_nxt_s = RUN_ONE;
    end else if (active_det_s && !clr) begin
      if (run_base_s == RUN_MAX) begin
        run_nxt_s = RUN_MAX;
      end else begin
        run_nxt_s = run_base_s + RUN_ONE;
      end
    end else begin
      run_nxt_s = run_base_s;
    end

    if (run_nxt_s > max_base_s) begin
      max_nxt_s = run_nxt_s;
    end else begin
      max_nxt_s = max_base_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      hit_pulse <= 1'b0;
      hit_bcd   <= 8'h00;
      wrapped   <= 1'b0;
      run_len   <= {RUN_W{1'b0}};
      max_run   <= {RUN_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      hit_pulse <= event_s;
      hit_bcd   <= bcd_nxt_s;
      wrapped   <= wrapped_nxt_s;
      run_len   <= run_nxt_s;
      max_run   <= max_nxt_s;
    end
  end

  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex0 (
    .digit (hit_bcd[3:0]),
    .seg   (hex0)
  );

  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex1 (
    .digit (hit_bcd[7:4]),
    .seg   (hex1)
  );

endmodule
